// File: rtl/branch_pkg.sv
// Shared constants for the branch unit: opcode class, branch
// function codes and condition-flag bit positions.
package branch_pkg;

   localparam logic [1:0] OPC_BRANCH = 2'b11;

   localparam logic [3:0] FC_RET  = 4'b0000;
   localparam logic [3:0] FC_JR   = 4'b0001;
   localparam logic [3:0] FC_JMP  = 4'b0010;
   localparam logic [3:0] FC_BZ   = 4'b0011;
   localparam logic [3:0] FC_BNZ  = 4'b0100;
   localparam logic [3:0] FC_BC   = 4'b0101;
   localparam logic [3:0] FC_BNC  = 4'b0110;
   localparam logic [3:0] FC_BS   = 4'b0111;
   localparam logic [3:0] FC_BNS  = 4'b1000;
   localparam logic [3:0] FC_BO   = 4'b1001;
   localparam logic [3:0] FC_BNO  = 4'b1010;
   localparam logic [3:0] FC_CALL = 4'b1011;

   // bit positions inside the packed {z,c,s,o} flag word
   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_S = 1;
   localparam int FLAG_O = 0;

endpackage

// File: rtl/branch_ras.sv
// Circular return-address stack. Ports: clk, rst (sync, active-low),
// push/push_data, pop, top (entry below ptr), count, sticky overflow.
module branch_ras #(
   parameter int ADDR_W    = 26,
   parameter int RAS_DEPTH = 8,
   parameter int RAS_PTR_W = $clog2(RAS_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_data,
   input  logic              pop,
   output logic [ADDR_W-1:0] top,
   output logic [RAS_PTR_W:0] count,
   output logic              overflow
);

   localparam logic [RAS_PTR_W:0] FULL = (RAS_PTR_W+1)'(RAS_DEPTH);

   logic [ADDR_W-1:0]    mem [RAS_DEPTH];
   logic [RAS_PTR_W-1:0] ptr;

   // pointer arithmetic wraps naturally since depth is a power of two
   assign top = mem[ptr - 1'b1];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr      <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (push) begin
         ptr <= ptr + 1'b1;
         if (count == FULL) begin
            overflow <= 1'b1;
         end else begin
            count <= count + 1'b1;
         end
      end else if (pop && count != '0) begin
         ptr   <= ptr - 1'b1;
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/branch_unit_ras.sv
// Branch resolver with flag bypass, RAS call/return and flush;
// all results registered, 1-cycle latency. Ports: decode inputs
// (in_valid, opcode, fcode, offset_in, reg_val, pc_in), ALU flags
// (flag_we, z/c/s/o_in), flush; outputs br_valid/taken/target,
// ras_overflow (sticky), ras_underflow (pulse).
// Define BRANCH_STATS_EN to add taken_cnt/resolved_cnt counters.
module branch_unit_ras
   import branch_pkg::*;
#(
   parameter int ADDR_W    = 26,
   parameter int RAS_DEPTH = 8,
   parameter int RAS_PTR_W = $clog2(RAS_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [1:0]        opcode,
   input  logic [3:0]        fcode,
   input  logic [ADDR_W-1:0] offset_in,
   input  logic [31:0]       reg_val,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              flag_we,
   input  logic              z_in,
   input  logic              c_in,
   input  logic              s_in,
   input  logic              o_in,
   input  logic              flush,
   output logic              br_valid,
   output logic              br_taken,
   output logic [ADDR_W-1:0] br_target,
   output logic              ras_overflow,
   output logic              ras_underflow
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]       taken_cnt,
   output logic [31:0]       resolved_cnt
`endif
);

   logic [3:0]          flags_q;
   logic [3:0]          flags;
   logic                accept;
   logic                valid_d;
   logic                taken_d;
   logic [ADDR_W-1:0]   target_d;
   logic                unf_d;
   logic                push;
   logic                pop;
   logic [ADDR_W-1:0]   ras_top;
   logic [RAS_PTR_W:0]  ras_count;
   logic [ADDR_W-1:0]   reg_tgt;
   logic                unused_reg_hi;

   assign reg_tgt       = reg_val[ADDR_W-1:0];
   assign unused_reg_hi = ^reg_val[31:ADDR_W];

   // same-cycle flag writes are visible to the branch being resolved
   assign flags  = flag_we ? {z_in, c_in, s_in, o_in} : flags_q;
   assign accept = in_valid && !flush && (opcode == OPC_BRANCH);
   assign valid_d = in_valid && !flush;

   always_ff @(posedge clk) begin
      if (!rst) begin
         flags_q <= 4'b0;
      end else if (flag_we) begin
         flags_q <= {z_in, c_in, s_in, o_in};
      end
   end

   always_comb begin
      taken_d  = 1'b0;
      target_d = '0;
      unf_d    = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      if (accept) begin
         case (fcode)
            FC_JMP:  taken_d = 1'b1;
            FC_JR:   taken_d = 1'b1;
            FC_BZ:   taken_d = flags[FLAG_Z];
            FC_BNZ:  taken_d = !flags[FLAG_Z];
            FC_BC:   taken_d = flags[FLAG_C];
            FC_BNC:  taken_d = !flags[FLAG_C];
            FC_BS:   taken_d = flags[FLAG_S];
            FC_BNS:  taken_d = !flags[FLAG_S];
            FC_BO:   taken_d = flags[FLAG_O];
            FC_BNO:  taken_d = !flags[FLAG_O];
            FC_CALL: begin
               taken_d = 1'b1;
               push    = 1'b1;
            end
            FC_RET: begin
               taken_d = 1'b1;
               pop     = (ras_count != '0);
               unf_d   = (ras_count == '0);
            end
            default: taken_d = 1'b0;
         endcase
         if (taken_d) begin
            if (fcode == FC_JR) begin
               target_d = reg_tgt;
            end else if (fcode == FC_RET) begin
               target_d = unf_d ? reg_tgt : ras_top;
            end else begin
               target_d = offset_in;
            end
         end
      end
   end

   branch_ras #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH),
      .RAS_PTR_W (RAS_PTR_W)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (pc_in + ADDR_W'(1)),
      .pop       (pop),
      .top       (ras_top),
      .count     (ras_count),
      .overflow  (ras_overflow)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         br_valid      <= 1'b0;
         br_taken      <= 1'b0;
         br_target     <= '0;
         ras_underflow <= 1'b0;
      end else begin
         br_valid      <= valid_d;
         br_taken      <= taken_d;
         br_target     <= target_d;
         ras_underflow <= unf_d;
      end
   end

`ifdef BRANCH_STATS_EN
   // counted alongside the registered result so they track br_valid/br_taken
   always_ff @(posedge clk) begin
      if (!rst) begin
         resolved_cnt <= '0;
         taken_cnt    <= '0;
      end else begin
         resolved_cnt <= resolved_cnt + {31'b0, valid_d};
         taken_cnt    <= taken_cnt + {31'b0, taken_d};
      end
   end
`endif

endmodule
